// File: rtl/bin2bcd_pkg.sv
// Shared types and default sizing for the sequential binary-to-BCD converter.
// Optional build macro: LEADING_ZERO_BLANK_EN (leading-zero blank flags).
package bin2bcd_pkg;

  localparam int BIN_W_DEF   = 20;
  localparam int DIGITS_DEF  = 6;
  localparam int BCD_MAX_DEF = 999999;

  // Shift counter must hold 0..BIN_W
  localparam int CNT_W_DEF   = $clog2(BIN_W_DEF + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/bcd_digit_adj.sv
// Single-digit double-dabble correction: a digit of 5 or more gets +3 so the
// following left shift carries correctly into the next decimal digit.
module bcd_digit_adj (
  input  logic [3:0] d_i,
  output logic [3:0] d_o
);

  // Add 3 when the digit would reach 10 or more after doubling
  always_comb begin
    d_o = d_i;
    if (d_i >= 4'd5) begin
      d_o = d_i + 4'd3;
    end
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3), one input bit per clock.
// Feeds the 6-digit seven-segment scanner: bcd_out/ovf only change when a
// conversion completes, so the scanner never sees a partial result.
// Optional build macro: LEADING_ZERO_BLANK_EN drives blank_mask; without it
// blank_mask is tied to zero.
//
// Handshake: start is sampled only while idle (busy=0); the edge that sees
// start=1 in IDLE accepts bin_in. busy then stays high for BIN_W+1 cycles and
// done pulses for one cycle in the last of them, with bcd_out/ovf already
// updated. start while busy is dropped, never queued.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int BIN_W   = BIN_W_DEF,
  parameter int DIGITS  = DIGITS_DEF,
  parameter int BCD_MAX = BCD_MAX_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  ovf,
  output logic [DIGITS-1:0]     blank_mask,
  output logic [1:0]            dbg_state_o
);

  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam int BCD_W = 4 * DIGITS;
  localparam logic [BIN_W-1:0] BCD_MAX_V = BIN_W'(BCD_MAX);
  localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(BIN_W - 1);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BIN_W-1:0]     bin_q, bin_d;
  logic [BCD_W-1:0]     bcd_q, bcd_d;
  logic                 ovf_pend_q, ovf_pend_d;
  logic [BCD_W-1:0]     bcd_out_q, bcd_out_d;
  logic                 ovf_q, ovf_d;

  logic [BCD_W-1:0]       adj;
  logic [BCD_W+BIN_W-1:0] work_sh;
  logic                   last_shift;

  // Per-digit +3 correction applied to the working BCD register
  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .d_i (bcd_q[4*g +: 4]),
      .d_o (adj[4*g +: 4])
    );
  end

  assign work_sh    = {adj, bin_q} << 1;
  assign last_shift = (state_q == S_SHIFT) && (cnt_q == LAST_SHIFT);

  // State and working registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bin_q      <= '0;
      bcd_q      <= '0;
      ovf_pend_q <= 1'b0;
      bcd_out_q  <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      ovf_pend_q <= ovf_pend_d;
      bcd_out_q  <= bcd_out_d;
      ovf_q      <= ovf_d;
    end
  end

  // Next-state, datapath update and handshake outputs
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bin_d      = bin_q;
    bcd_d      = bcd_q;
    ovf_pend_d = ovf_pend_q;
    bcd_out_d  = bcd_out_q;
    ovf_d      = ovf_q;
    busy       = 1'b0;
    done       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SHIFT;
          cnt_d   = '0;
          bcd_d   = '0;
          // Out-of-range operands saturate so the display shows all nines
          if (bin_in > BCD_MAX_V) begin
            bin_d      = BCD_MAX_V;
            ovf_pend_d = 1'b1;
          end else begin
            bin_d      = bin_in;
            ovf_pend_d = 1'b0;
          end
        end
      end
      S_SHIFT: begin
        busy  = 1'b1;
        bcd_d = work_sh[BCD_W+BIN_W-1:BIN_W];
        bin_d = work_sh[BIN_W-1:0];
        cnt_d = cnt_q + CNT_W'(1);
        // Final result is published on the edge into DONE so it is visible
        // in the same cycle as the done pulse
        if (last_shift) begin
          state_d   = S_DONE;
          bcd_out_d = work_sh[BCD_W+BIN_W-1:BIN_W];
          ovf_d     = ovf_pend_q;
        end
      end
      S_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bcd_out     = bcd_out_q;
  assign ovf         = ovf_q;
  assign dbg_state_o = state_q;

`ifdef LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0] blank_q, blank_d, blank_calc;
  logic              zero_above;

  // Flag each digit that is zero with only zeros above it; digit 0 always shown
  always_comb begin
    blank_calc = '0;
    zero_above = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_above    = zero_above && (work_sh[BIN_W + 4*i +: 4] == 4'd0);
      blank_calc[i] = zero_above;
    end
    blank_d = last_shift ? blank_calc : blank_q;
  end

  // Blank flags update together with bcd_out
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blank_q <= '0;
    end else begin
      blank_q <= blank_d;
    end
  end

  assign blank_mask = blank_q;
`else
  assign blank_mask = '0;
`endif

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed bench for bin2bcd_seq: reset values, latency/busy length, overflow
// saturation, ignored start while busy, mid-conversion reset, back-to-back.
module tb_bin2bcd_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [19:0] bin_in;
  logic        busy;
  logic        done;
  logic [23:0] bcd_out;
  logic        ovf;
  logic [5:0]  blank_mask;
  logic [1:0]  dbg_state;

  int tests = 0;
  int fails = 0;

  // Clock and DUT
  always #5 clk = ~clk;

  bin2bcd_seq dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .bin_in      (bin_in),
    .busy        (busy),
    .done        (done),
    .bcd_out     (bcd_out),
    .ovf         (ovf),
    .blank_mask  (blank_mask),
    .dbg_state_o (dbg_state)
  );

  function automatic logic [5:0] mask_exp(input logic [5:0] m);
`ifdef LEADING_ZERO_BLANK_EN
    return m;
`else
    return 6'b0 & m;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present start for one accept edge; returns at the negedge of cycle N+1
  task automatic launch(input logic [19:0] v);
    @(negedge clk);
    start  = 1'b1;
    bin_in = v;
    @(negedge clk);
    start  = 1'b0;
  endtask

  // Walk negedges from cycle index k0 until done, bounded at 40 cycles
  task automatic wait_done(input int k0, output int cyc, output int busy_n);
    int k;
    k      = k0;
    busy_n = 0;
    while (k <= 40 && !done) begin
      if (busy) busy_n++;
      @(negedge clk);
      k++;
    end
    if (busy) busy_n++;
    cyc = k;
  endtask

  task automatic run_conv(input string tag, input logic [19:0] v, input logic [23:0] eb,
                          input logic eo, input logic [5:0] em);
    int cyc, bn;
    launch(v);
    wait_done(1, cyc, bn);
    check({tag, "_latency"}, 32'(cyc), 32'd21);
    check({tag, "_busy_cycles"}, 32'(bn), 32'd21);
    check({tag, "_bcd"}, 32'(bcd_out), 32'(eb));
    check({tag, "_ovf"}, 32'(ovf), 32'(eo));
    check({tag, "_blank"}, 32'(blank_mask), 32'(mask_exp(em)));
    @(negedge clk);
    check({tag, "_done_single"}, 32'(done), 32'd0);
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
    check({tag, "_bcd_hold"}, 32'(bcd_out), 32'(eb));
  endtask

  initial begin
    int cyc, bn, extra, gap;
    logic stable_ok;
    logic [23:0] prev;

    // Reset state
    rst_n  = 1'b0;
    start  = 1'b0;
    bin_in = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_bcd", 32'(bcd_out), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_blank", 32'(blank_mask), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Zero input, typical value, range limits and saturation
    run_conv("zero", 20'd0, 24'h000000, 1'b0, 6'b111110);
    run_conv("v12345", 20'd12345, 24'h012345, 1'b0, 6'b100000);
    run_conv("max", 20'd999999, 24'h999999, 1'b0, 6'b000000);
    run_conv("ovf", 20'd1000000, 24'h999999, 1'b1, 6'b000000);
    run_conv("v7", 20'd7, 24'h000007, 1'b0, 6'b111110);

    // start during SHIFT is dropped
    launch(20'd42);
    repeat (4) @(negedge clk);
    start  = 1'b1;
    bin_in = 20'd77;
    @(negedge clk);
    start  = 1'b0;
    wait_done(6, cyc, bn);
    check("ign_latency", 32'(cyc), 32'd21);
    check("ign_bcd", 32'(bcd_out), 32'h000042);
    check("ign_blank", 32'(blank_mask), 32'(mask_exp(6'b111100)));
    extra = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done) extra++;
    end
    check("ign_no_second_done", 32'(extra), 32'd0);
    check("ign_bcd_hold", 32'(bcd_out), 32'h000042);

    // Reset in the middle of a conversion
    launch(20'd54321);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_bcd", 32'(bcd_out), 32'd0);
    check("mid_rst_ovf", 32'(ovf), 32'd0);
    check("mid_rst_blank", 32'(blank_mask), 32'd0);
    check("mid_rst_state", 32'(dbg_state), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_conv("after_rst", 20'd54321, 24'h054321, 1'b0, 6'b100000);

    // Back-to-back with start held high
    @(negedge clk);
    start     = 1'b1;
    bin_in    = 20'd1;
    prev      = 24'h054321;
    stable_ok = 1'b1;
    for (int idx = 0; idx < 3; idx++) begin
      gap = 0;
      do begin
        @(negedge clk);
        gap++;
        if (!done && bcd_out !== prev) stable_ok = 1'b0;
      end while (!done && gap < 40);
      check($sformatf("b2b%0d_gap", idx), 32'(gap), (idx == 0) ? 32'd21 : 32'd22);
      check($sformatf("b2b%0d_bcd", idx), 32'(bcd_out), 32'(idx + 1));
      prev = 24'(idx + 1);
      if (idx < 2) bin_in = 20'(idx + 2);
      else start = 1'b0;
    end
    check("b2b_stable", 32'(stable_ok), 32'd1);
    @(negedge clk);
    check("b2b_end_state", 32'(dbg_state), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
